// File: rtl/seven_seg_mux_driver.sv
// seven_seg_mux_driver
//   Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits
//   sharing one segment bus. Provides per-digit decimal points, per-digit
//   blink, leading-zero suppression, anti-ghost anode blanking at the start
//   of every digit slot, and frame-synchronous (tear-free) display updates.
//
// Ports
//   clk, rst_n   : system clock, asynchronous active-low reset
//   disp_On      : 1 = display enabled, 0 = outputs dark (counters keep running)
//   bcd_in       : 4*NUM_DIGITS digit values, nibble k = digit k (digit 0 = LSD)
//   dp_in        : decimal-point request per digit, 1 = lit
//   blink_mask   : 1 = digit blinks
//   lz_suppress  : 1 = blank leading zeros (digit 0 is never suppressed)
//   load         : capture bcd_in/dp_in/blink_mask into the pending register
//   seg_Out      : segments {g,f,e,d,c,b,a}, active low
//   dp_Out       : decimal point, active low
//   an_Out       : anode enables, active low, one-hot-low
//   frame_tick   : one-cycle pulse when scanning returns to digit 0
module seven_seg_mux_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2,
    parameter int BLINK_DIV    = 250
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      disp_On,
    input  logic [4*NUM_DIGITS-1:0]   bcd_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    input  logic                      lz_suppress,
    input  logic                      load,
    output logic [6:0]                seg_Out,
    output logic                      dp_Out,
    output logic [NUM_DIGITS-1:0]     an_Out,
    output logic                      frame_tick
);

    localparam int SLOT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int FC_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    // Scan / blink timing state
    logic [SLOT_W-1:0]       slot_cnt_q,   slot_cnt_d;
    logic [IDX_W-1:0]        digit_idx_q,  digit_idx_d;
    logic [FC_W-1:0]         frame_cnt_q,  frame_cnt_d;
    logic                    blink_phase_q, blink_phase_d;

    // Pending (written by load) and display (frame-synchronous) registers
    logic [4*NUM_DIGITS-1:0] pend_bcd_q,   pend_bcd_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q,    pend_dp_d;
    logic [NUM_DIGITS-1:0]   pend_blink_q, pend_blink_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [4*NUM_DIGITS-1:0] disp_bcd_q,   disp_bcd_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q,    disp_dp_d;
    logic [NUM_DIGITS-1:0]   disp_blink_q, disp_blink_d;

    // Registered outputs
    logic [6:0]              seg_q,        seg_d;
    logic                    dp_q,         dp_d;
    logic [NUM_DIGITS-1:0]   an_q,         an_d;
    logic                    frame_tick_q, frame_tick_d;

    logic                    slot_wrap;
    logic                    frame_start;
    logic [3:0]              cur_bcd;
    logic                    cur_dp;
    logic                    cur_blink;
    logic                    cur_lz;
    logic [NUM_DIGITS-1:0]   lz_vec;
    logic                    zero_run;
    logic                    blanked;
    logic [6:0]              seg_dec;

    // Counters and frame-synchronous register transfer
    always_comb begin
        slot_wrap   = (slot_cnt_q == SLOT_W'(REFRESH_DIV - 1));
        frame_start = slot_wrap && (digit_idx_q == IDX_W'(NUM_DIGITS - 1));

        slot_cnt_d    = slot_wrap ? '0 : slot_cnt_q + 1'b1;
        digit_idx_d   = digit_idx_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (slot_wrap) begin
            digit_idx_d = frame_start ? '0 : digit_idx_q + 1'b1;
        end
        if (frame_start) begin
            if (frame_cnt_q == FC_W'(BLINK_DIV - 1)) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end

        pend_bcd_d   = pend_bcd_q;
        pend_dp_d    = pend_dp_q;
        pend_blink_d = pend_blink_q;
        pend_valid_d = pend_valid_q;
        disp_bcd_d   = disp_bcd_q;
        disp_dp_d    = disp_dp_q;
        disp_blink_d = disp_blink_q;
        // Transfer first, then capture: a load coinciding with frame start
        // lands in pending and keeps pending_valid set for the next frame.
        if (frame_start && pend_valid_q) begin
            disp_bcd_d   = pend_bcd_q;
            disp_dp_d    = pend_dp_q;
            disp_blink_d = pend_blink_q;
            pend_valid_d = 1'b0;
        end
        if (load) begin
            pend_bcd_d   = bcd_in;
            pend_dp_d    = dp_in;
            pend_blink_d = blink_mask;
            pend_valid_d = 1'b1;
        end
    end

    // Current-digit selection and leading-zero detection
    always_comb begin
        cur_bcd   = '0;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        cur_lz    = 1'b0;
        lz_vec    = '0;
        zero_run  = 1'b1;
        // Walk from the most significant digit down; a digit is a leading
        // zero while every digit above it (and itself) is zero.
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            zero_run = zero_run & (disp_bcd_q[4*(NUM_DIGITS-1-i) +: 4] == 4'd0);
            lz_vec[NUM_DIGITS-1-i] = zero_run;
        end
        lz_vec[0] = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx_q == IDX_W'(i)) begin
                cur_bcd   = disp_bcd_q[4*i +: 4];
                cur_dp    = disp_dp_q[i];
                cur_blink = disp_blink_q[i];
                cur_lz    = lz_vec[i];
            end
        end
    end

    // Decode and output formation
    always_comb begin
        case (cur_bcd)
            4'd0:    seg_dec = 7'h40;
            4'd1:    seg_dec = 7'h79;
            4'd2:    seg_dec = 7'h24;
            4'd3:    seg_dec = 7'h30;
            4'd4:    seg_dec = 7'h19;
            4'd5:    seg_dec = 7'h12;
            4'd6:    seg_dec = 7'h02;
            4'd7:    seg_dec = 7'h78;
            4'd8:    seg_dec = 7'h00;
            4'd9:    seg_dec = 7'h10;
            default: seg_dec = 7'h7F;
        endcase

        blanked = (cur_blink && blink_phase_q) || (lz_suppress && cur_lz);

        seg_d        = 7'h7F;
        dp_d         = 1'b1;
        an_d         = '1;
        frame_tick_d = frame_start;
        if (disp_On) begin
            if (!blanked) begin
                seg_d = seg_dec;
                dp_d  = ~cur_dp;
            end
            if (slot_cnt_q >= SLOT_W'(BLANK_CYCLES)) begin
                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                    an_d[i] = (digit_idx_q != IDX_W'(i));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q    <= '0;
            digit_idx_q   <= '0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            pend_bcd_q    <= '0;
            pend_dp_q     <= '0;
            pend_blink_q  <= '0;
            pend_valid_q  <= 1'b0;
            disp_bcd_q    <= '0;
            disp_dp_q     <= '0;
            disp_blink_q  <= '0;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
            an_q          <= '1;
            frame_tick_q  <= 1'b0;
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            digit_idx_q   <= digit_idx_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            pend_bcd_q    <= pend_bcd_d;
            pend_dp_q     <= pend_dp_d;
            pend_blink_q  <= pend_blink_d;
            pend_valid_q  <= pend_valid_d;
            disp_bcd_q    <= disp_bcd_d;
            disp_dp_q     <= disp_dp_d;
            disp_blink_q  <= disp_blink_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign seg_Out    = seg_q;
    assign dp_Out     = dp_q;
    assign an_Out     = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_mux_driver.sv
// tb_seven_seg_mux_driver
//   Self-checking bench for seven_seg_mux_driver (4 digits, 8-cycle slots,
//   2 blank cycles, blink every 2 frames). Expected outputs come from a
//   cycle-indexed model: scan position, frame number and blink phase are
//   derived arithmetically from the cycle count since reset release.
module tb_seven_seg_mux_driver;

    localparam int N     = 4;
    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int BD    = 2;
    localparam int FRAME = RD * N;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        disp_On = 1'b1;
    logic [15:0] bcd_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blink_mask = '0;
    logic        lz_suppress = 1'b0;
    logic        load = 1'b0;
    logic [6:0]  seg_Out;
    logic        dp_Out;
    logic [3:0]  an_Out;
    logic        frame_tick;

    seven_seg_mux_driver #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC),
        .BLINK_DIV   (BD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .disp_On    (disp_On),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .blink_mask (blink_mask),
        .lz_suppress(lz_suppress),
        .load       (load),
        .seg_Out    (seg_Out),
        .dp_Out     (dp_Out),
        .an_Out     (an_Out),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

    // Model state
    int unsigned t;
    logic [15:0] pend_bcd, disp_bcd;
    logic [3:0]  pend_dp, pend_bm, disp_dp, disp_bm;
    bit          pend_v;

    // {frame_tick, an, dp, seg}
    logic [12:0] exp_v;
    wire  [12:0] obs = {frame_tick, an_Out, dp_Out, seg_Out};
    localparam logic [12:0] DARK = {1'b0, 4'hF, 1'b1, 7'h7F};

    task automatic model_reset();
        t = 0;
        pend_bcd = '0; disp_bcd = '0;
        pend_dp = '0; pend_bm = '0; disp_dp = '0; disp_bm = '0;
        pend_v = 1'b0;
    endtask

    // Predict the outputs produced by the next clock edge from the current
    // cycle count and live inputs, advance the model, then step the clock.
    task automatic tick();
        int unsigned slot, idx, fs;
        bit phase, blank, fstart;
        logic [6:0] s;
        logic dpv;
        logic [3:0] an;
        logic [3:0] dig;
        slot   = t % RD;
        idx    = (t / RD) % N;
        fs     = t / FRAME;
        phase  = ((fs / BD) % 2) == 1;
        fstart = ((t + 1) % FRAME) == 0;
        dig    = 4'((disp_bcd >> (4 * idx)) & 16'hF);
        blank  = (disp_bm[idx] && phase) ||
                 (lz_suppress && idx != 0 && (disp_bcd >> (4 * idx)) == 16'd0);
        s = 7'h7F; dpv = 1'b1; an = 4'hF;
        if (disp_On) begin
            if (!blank) begin
                s   = seg_tab[dig];
                dpv = ~disp_dp[idx];
            end
            if (slot >= BC) an = ~(4'b1 << idx);
        end
        exp_v = {fstart, an, dpv, s};
        if (fstart && pend_v) begin
            disp_bcd = pend_bcd; disp_dp = pend_dp; disp_bm = pend_bm;
            pend_v = 1'b0;
        end
        if (load) begin
            pend_bcd = bcd_in; pend_dp = dp_in; pend_bm = blink_mask;
            pend_v = 1'b1;
        end
        t++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tests_run++;
        if (obs !== DARK) begin
            tests_failed++;
            $display("FAIL reset_state got %h want %h", obs, DARK);
        end
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < FRAME + 4; i++) begin
            tick();
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL reset_scan t=%0d got %h want %h", t, obs, exp_v);
            end
        end
    endtask

    task automatic test_decode();
        int ticks, d0_hits, d3_hits;
        while (t % FRAME != 0) begin
            tick();
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL decode_align t=%0d got %h want %h", t, obs, exp_v);
            end
        end
        bcd_in = 16'h1234; load = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            load = 1'b0;
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL decode_pre t=%0d got %h want %h", t, obs, exp_v);
            end
        end
        ticks = 0; d0_hits = 0; d3_hits = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (frame_tick) ticks++;
            if (an_Out == 4'b1110 && seg_Out == 7'h19) d0_hits++;
            if (an_Out == 4'b0111 && seg_Out == 7'h79) d3_hits++;
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL decode_1234 t=%0d got %h want %h", t, obs, exp_v);
            end
        end
        tests_run++;
        if (ticks != 1) begin
            tests_failed++;
            $display("FAIL frame_tick_rate got %0d want 1", ticks);
        end
        tests_run++;
        if (d0_hits != RD - BC) begin
            tests_failed++;
            $display("FAIL digit0_lit_cycles got %0d want %0d", d0_hits, RD - BC);
        end
        tests_run++;
        if (d3_hits != RD - BC) begin
            tests_failed++;
            $display("FAIL digit3_lit_cycles got %0d want %0d", d3_hits, RD - BC);
        end
    endtask

    task automatic test_lz_suppress();
        lz_suppress = 1'b1;
        for (int i = 0; i < 6 * FRAME; i++) begin
            if (i == 0)              begin bcd_in = 16'h0070; load = 1'b1; end
            else if (i == 3 * FRAME) begin bcd_in = 16'h0000; load = 1'b1; end
            else load = 1'b0;
            tick();
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL lz_suppress t=%0d got %h want %h", t, obs, exp_v);
            end
        end
        lz_suppress = 1'b0;
    endtask

    task automatic test_blink();
        bcd_in = 16'h5678; blink_mask = 4'b0001; load = 1'b1;
        for (int i = 0; i < 7 * FRAME; i++) begin
            tick();
            load = 1'b0;
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL blink t=%0d got %h want %h", t, obs, exp_v);
            end
        end
        blink_mask = 4'b0000; load = 1'b1;
        tick();
        load = 1'b0;
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL blink_clear t=%0d got %h want %h", t, obs, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (i == 0)               begin bcd_in = 16'h1111; load = 1'b1; end
            else if (i == FRAME + 12) begin bcd_in = 16'h2222; load = 1'b1; end
            else if (i == FRAME + 13) begin bcd_in = 16'h3333; load = 1'b1; end
            else load = 1'b0;
            tick();
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL back_to_back t=%0d got %h want %h", t, obs, exp_v);
            end
        end
    endtask

    task automatic test_invalid_dp();
        bcd_in = 16'hABCD; dp_in = 4'b0100; load = 1'b1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            load = 1'b0;
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL invalid_dp t=%0d got %h want %h", t, obs, exp_v);
            end
        end
        dp_in = 4'b0000;
    endtask

    task automatic test_disp_off();
        bcd_in = 16'h9081; load = 1'b1;
        for (int i = 0; i < 4 * FRAME; i++) begin
            if (i == FRAME + 5) disp_On = 1'b0;
            if (i == 3 * FRAME + 3) disp_On = 1'b1;
            tick();
            load = 1'b0;
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL disp_off t=%0d got %h want %h", t, obs, exp_v);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            load = ($urandom_range(0, 15) == 0);
            if (load) begin
                bcd_in     = ($urandom_range(0, 3) == 0) ? 16'($urandom) :
                             {4'($urandom_range(0, 9)) & {4{$urandom_range(0, 1) == 1}},
                              4'($urandom_range(0, 9)) & {4{$urandom_range(0, 1) == 1}},
                              4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                dp_in      = 4'($urandom);
                blink_mask = 4'($urandom);
            end
            if ($urandom_range(0, 63) == 0) lz_suppress = ~lz_suppress;
            if ($urandom_range(0, 99) == 0) disp_On = ~disp_On;
            tick();
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL random t=%0d got %h want %h", t, obs, exp_v);
            end
        end
        load = 1'b0; disp_On = 1'b1; lz_suppress = 1'b0;
    endtask

    task automatic test_reset_mid();
        bcd_in = 16'h4321; dp_in = 4'b1111; load = 1'b1;
        for (int i = 0; i < FRAME + 19; i++) begin
            tick();
            load = 1'b0;
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL pre_reset t=%0d got %h want %h", t, obs, exp_v);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (obs !== DARK) begin
            tests_failed++;
            $display("FAIL async_reset got %h want %h", obs, DARK);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (obs !== DARK) begin
            tests_failed++;
            $display("FAIL held_reset got %h want %h", obs, DARK);
        end
        rst_n = 1'b1;
        dp_in = 4'b0000;
        model_reset();
        for (int i = 0; i < FRAME + 8; i++) begin
            tick();
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL post_reset t=%0d got %h want %h", t, obs, exp_v);
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_decode();
        test_lz_suppress();
        test_blink();
        test_back_to_back();
        test_invalid_dp();
        test_disp_off();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
